instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: MEM_BYTES, default 1024, byte size of the instruction store; legal write addresses are 0 .. MEM_BYTES-4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-005 base_addr  input  32  byte address of the first word; sampled with start.
REQ-006 word_count  input  16  number of 32-bit words to load; sampled with start.
REQ-007 in_valid  input  1  byte-stream data valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  instruction-store word write strobe.
REQ-011 mem_addr  output  32  byte address of the word written; always a multiple of 4 when mem_we=1.
REQ-012 mem_wdata  output  32  word written.
REQ-013 busy  output  1  high in LOAD, WRITE and DONE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  sticky out-of-range flag.

Function
REQ-016 States: IDLE, LOAD, WRITE, DONE; encoding is free.
REQ-017 IDLE: in_ready=0, mem_we=0; start=1 with word_count!=0 latches base_addr with bits [1:0] forced to 0, latches word_count as remaining, clears err and the byte index, and moves to LOAD.
REQ-018 IDLE with start=1 and word_count=0: done=1 in the next cycle, err cleared, state stays IDLE, no write.
REQ-019 A byte transfer occurs only when in_valid=1 and in_ready=1 in the same cycle; in_data is ignored otherwise.
REQ-020 LOAD: in_ready=1; the k-th accepted byte of a word (k=0..3) goes to assembly bits [8k+7:8k] (little-endian); the byte index increments per transfer.
REQ-021 The transfer of byte 3 moves the FSM to WRITE; in_ready=0 in WRITE and DONE, so in_valid is held off by backpressure.
REQ-022 WRITE lasts exactly one cycle: mem_we=1, mem_addr=current address, mem_wdata=assembled word; mem_we is asserted the cycle after the 4th byte is accepted.
REQ-023 On leaving WRITE: address += 4 (mod 2^32), remaining -= 1, byte index = 0; next state is DONE if the new remaining is 0, else LOAD.
REQ-024 Out of range: if mem_addr > MEM_BYTES-4 in WRITE, mem_we is suppressed (0), err is set and stays set until the next accepted start, and the FSM still advances as in REQ-023.
REQ-025 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-026 start is ignored while busy=1; no restart and no parameter re-latch.
REQ-027 Maximum throughput is one word per 5 cycles (4 LOAD transfers + 1 WRITE).
REQ-028 mem_addr and mem_wdata hold their last values when mem_we=0; consumers qualify them with mem_we only.
REQ-029 word_count=65535 is legal; remaining never underflows.

Reset
REQ-030 reset=1 forces state IDLE, in_ready=0, mem_we=0, done=0, busy=0, err=0, byte index 0, remaining 0, and mem_addr=mem_wdata=0 at the next edge.
REQ-031 reset dominates start and byte transfers in the same cycle; reset mid-load discards the partial word and writes nothing further.

Verification
REQ-032 start, base=0, count=1; bytes 13,02,12,00 on consecutive cycles -> one mem_we at addr 0x0, data 0x00120213; done one cycle after the write; busy low the cycle after done.
REQ-033 base=0x10, count=2; bytes for 0x00110113 then 0xFE9FF06F with in_valid toggling every other cycle -> writes at 0x10 and 0x14 with the correct data, in_ready=0 during each WRITE, exactly 2 mem_we pulses.
REQ-034 start with count=0 -> done pulse the next cycle, no mem_we, busy stays 0.
REQ-035 MEM_BYTES=1024, base=0x3FC, count=2 -> write at 0x3FC occurs; second word gets no mem_we and err=1; done still pulses; err clears on the next start.
REQ-036 reset asserted after 2 bytes of a word -> no mem_we, all outputs at reset values; a new start then loads correctly from byte 0.
REQ-037 start pulsed during LOAD with different base/count -> ignored; the original load completes unchanged.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Assembles a little-endian byte stream into 32-bit words and writes them
// into an instruction store starting at a word-aligned base address.
//
// Ports
//   clk         system clock, rising-edge
//   reset       synchronous active-high reset
//   start       one-cycle load request, only honoured in IDLE
//   base_addr   byte address of the first word (bits [1:0] ignored)
//   word_count  number of words to load; 0 completes immediately
//   in_valid    byte-stream valid
//   in_data     byte-stream data
//   in_ready    loader accepts a byte this cycle
//   mem_we      word write strobe
//   mem_addr    word byte address, held between writes
//   mem_wdata   word data, held between writes
//   busy        load in progress (LOAD, WRITE, DONE)
//   done        one-cycle completion pulse
//   err         sticky out-of-range flag, cleared by the next accepted start
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | accepting bytes 0..3 of the current word
// S_WRITE | one cycle: write the assembled word (if in range)
// S_DONE  | one cycle: completion pulse, then back to IDLE
module instr_mem_loader #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [15:0] r_remaining;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_asm;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_err;
    logic        r_done_zero;

    logic        w_xfer;
    logic        w_last_byte;
    logic        w_start_load;
    logic        w_start_zero;
    logic        w_in_range;

    assign w_xfer       = in_valid && (r_state == S_LOAD);
    assign w_last_byte  = w_xfer && (r_byte_idx == 2'd3);
    assign w_start_load = (r_state == S_IDLE) && start && (word_count != 16'd0);
    assign w_start_zero = (r_state == S_IDLE) && start && (word_count == 16'd0);
    assign w_in_range   = (r_addr <= LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_load) w_next = S_LOAD;
            S_LOAD:  if (w_last_byte) w_next = S_WRITE;
            S_WRITE: w_next = (r_remaining == 16'd1) ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The write strobe and the held address/data are registered on the 4th
    // byte transfer so they are valid exactly during the WRITE cycle and stay
    // put afterwards. An out-of-range word leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= 32'd0;
            r_remaining <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_asm       <= 24'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_err       <= 1'b0;
            r_done_zero <= 1'b0;
        end else begin
            r_mem_we    <= 1'b0;
            r_done_zero <= w_start_zero;

            if (w_start_load) begin
                r_addr      <= base_addr & ~32'h3;
                r_remaining <= word_count;
                r_byte_idx  <= 2'd0;
                r_err       <= 1'b0;
            end

            if (w_start_zero) begin
                r_err <= 1'b0;
            end

            if (w_xfer) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_asm[7:0]   <= in_data;
                    2'd1:    r_asm[15:8]  <= in_data;
                    2'd2:    r_asm[23:16] <= in_data;
                    default: begin
                        if (w_in_range) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_mem_wdata <= {in_data, r_asm};
                        end
                    end
                endcase
            end

            if (r_state == S_WRITE) begin
                r_addr      <= r_addr + 32'd4;
                r_remaining <= r_remaining - 16'd1;
                r_byte_idx  <= 2'd0;
                if (!w_in_range) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE) || r_done_zero;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus
// randomized loads checked against a word-level reference model.
module tb_instr_mem_loader;

    localparam int MEMB = 1024;
    localparam logic [31:0] LAST = 32'(MEMB - 4);

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    logic [7:0] fixed_bytes[$];

    instr_mem_loader #(.MEM_BYTES(MEMB)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) we_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // mode 0: in_valid always high, 1: toggling, 2: random
    task automatic do_load(input logic [31:0] base, input int cnt, input int mode,
                           input bit use_fixed, input bit glitch);
        logic [7:0]  bq[$];
        logic [31:0] addr;
        logic [31:0] word;
        int n_in, we0, idx, cyc, budget, w;
        bit v, xfer, exp_err;

        bq = {};
        for (int i = 0; i < cnt * 4; i++)
            bq.push_back(use_fixed ? fixed_bytes[i] : 8'($urandom));

        exp_err = 1'b0;
        n_in    = 0;
        for (int i = 0; i < cnt; i++) begin
            addr = {base[31:2], 2'b00} + 32'(4 * i);
            if (addr > LAST) exp_err = 1'b1;
            else n_in++;
        end
        we0 = we_cnt;

        @(negedge clk);
        start = 1'b1; base_addr = base; word_count = 16'(cnt);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);

        idx = 0; cyc = 0; budget = cnt * 40 + 20;
        while (idx < cnt * 4 && cyc < budget) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? bq[idx] : 8'($urandom);
            if (glitch && cyc == 2) begin
                start      = 1'b1;
                base_addr  = $urandom;
                word_count = 16'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            xfer = v && in_ready;
            @(negedge clk);
            cyc++;
            if (xfer) begin
                idx++;
                if (idx % 4 == 0) begin
                    w    = idx / 4 - 1;
                    addr = {base[31:2], 2'b00} + 32'(4 * w);
                    word = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
                    chk("we_in_write", {31'd0, mem_we}, {31'd0, (addr <= LAST)});
                    chk("ready_in_write", {31'd0, in_ready}, 32'd0);
                    if (addr <= LAST) begin
                        chk("mem_addr", mem_addr, addr);
                        chk("mem_wdata", mem_wdata, word);
                    end
                end
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("bytes_accepted", 32'(idx), 32'(cnt * 4));

        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        chk("we_in_done", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("err_final", {31'd0, err}, {31'd0, exp_err});
        chk("write_count", 32'(we_cnt - we0), 32'(n_in));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"},    {31'd0, mem_we},   32'd0);
        chk({tag, "_busy"},  {31'd0, busy},     32'd0);
        chk({tag, "_done"},  {31'd0, done},     32'd0);
        chk({tag, "_err"},   {31'd0, err},      32'd0);
        chk({tag, "_addr"},  mem_addr,          32'd0);
        chk({tag, "_wdata"}, mem_wdata,         32'd0);
    endtask

    task automatic zero_count_start(input logic [31:0] base);
        int we0;
        we0 = we_cnt;
        @(negedge clk);
        start = 1'b1; base_addr = base; word_count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_err_cleared", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("zero_done_off", {31'd0, done}, 32'd0);
        chk("zero_busy_off", {31'd0, busy}, 32'd0);
        chk("zero_no_write", 32'(we_cnt - we0), 32'd0);
    endtask

    initial begin
        int we0;
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        fixed_bytes = {8'h13, 8'h02, 8'h12, 8'h00};
        do_load(32'h0, 1, 0, 1'b1, 1'b0);

        fixed_bytes = {8'h13, 8'h01, 8'h11, 8'h00, 8'h6F, 8'hF0, 8'h9F, 8'hFE};
        do_load(32'h10, 2, 1, 1'b1, 1'b0);

        zero_count_start(32'h100);

        do_load(32'h3FC, 2, 0, 1'b0, 1'b0);
        zero_count_start(32'h0);

        do_load(32'hFFFF_FFFC, 2, 2, 1'b0, 1'b0);
        do_load(32'h0000_0203, 3, 2, 1'b0, 1'b0);

        // reset after two bytes of a word
        we0 = we_cnt;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h40; word_count = 16'd1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        in_data = 8'hBB;
        @(negedge clk);
        reset = 1'b1; in_data = 8'hCC; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; start = 1'b0;
        check_reset_outputs("midreset");
        repeat (6) @(negedge clk);
        chk("midreset_no_write", 32'(we_cnt - we0), 32'd0);
        do_load(32'h40, 1, 0, 1'b0, 1'b0);

        do_load(32'h80, 3, 0, 1'b0, 1'b1);

        for (int it = 0; it < 12; it++) begin
            logic [31:0] b;
            case ($urandom_range(0, 2))
                0:       b = $urandom & 32'h3FF;
                1:       b = 32'h3F0 + ($urandom & 32'hF);
                default: b = $urandom;
            endcase
            do_load(b, $urandom_range(1, 4), $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
